// File: rtl/ram_parity_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port, parity-protected RAM
// shared by two requesters; logs the count and address of read parity mismatches.
module ram_parity_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_perr,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_perr,
  input  logic                  err_inj,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    sel_b_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    ptr_b_q;
  logic                    start;
  logic                    sel_b_d;
  logic                    rd_perr;
  logic [DATA_WIDTH:0]     rd_word;
  logic [DATA_WIDTH:0]     mem [DEPTH];

  function automatic logic par(input logic [DATA_WIDTH-1:0] d);
    return ODD_PARITY ? ~^d : ^d;
  endfunction

  // B wins only when A is idle or the pointer favours B.
  assign start   = (state_q == IDLE) && (a_req || b_req);
  assign sel_b_d = b_req && (!a_req || ptr_b_q);
  assign rd_word = mem[addr_q];
  assign rd_perr = rd_word[DATA_WIDTH] != par(rd_word[DATA_WIDTH-1:0]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_req || b_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_b_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_b_q  <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_perr   <= 1'b0;
      b_perr   <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_perr   <= 1'b0;
      b_perr   <= 1'b0;
      if (start) begin
        sel_b_q <= sel_b_d;
        we_q    <= sel_b_d ? b_we    : a_we;
        addr_q  <= sel_b_d ? b_addr  : a_addr;
        wdata_q <= sel_b_d ? b_wdata : a_wdata;
        ptr_b_q <= !sel_b_d;
        a_gnt   <= !sel_b_d;
        b_gnt   <= sel_b_d;
      end
      if (state_q == ACCESS && !we_q) begin
        if (sel_b_q) begin
          b_rvalid <= 1'b1;
          b_rdata  <= rd_word[DATA_WIDTH-1:0];
          b_perr   <= rd_perr;
        end else begin
          a_rvalid <= 1'b1;
          a_rdata  <= rd_word[DATA_WIDTH-1:0];
          a_perr   <= rd_perr;
        end
      end
      // Error log commits on leaving RESP, so a reset there drops the update.
      if (state_q == RESP && (a_perr || b_perr)) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        err_addr <= addr_q;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst_n, only the write is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == ACCESS && we_q)
      mem[addr_q] <= {par(wdata_q) ^ err_inj, wdata_q};
  end

endmodule

// File: tb/tb_ram_parity_arbiter.sv
// Directed bench for ram_parity_arbiter: latency, arbitration order, parity
// injection, error-count saturation, reset during access and sustained contention.
module tb_ram_parity_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we, err_inj;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, a_perr, b_gnt, b_rvalid, b_perr;
  logic [7:0] a_rdata, b_rdata, err_cnt, err_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_parity_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_perr(a_perr),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_perr(b_perr),
    .err_inj(err_inj), .err_cnt(err_cnt), .err_addr(err_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE back to IDLE; gl = cycles until gnt was seen.
  task automatic xact(input bit side, input bit we, input logic [7:0] addr,
                      input logic [7:0] wd, input bit inj, output int gl,
                      output logic rv, output logic [7:0] rd, output logic pe);
    if (!side) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else       begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    err_inj = inj;
    gl = 0; rv = 1'b0; rd = '0; pe = 1'b0;
    do begin
      tick();
      gl++;
    end while (!(side ? b_gnt : a_gnt) && gl < 20);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    err_inj = 1'b0;
    if (!we) begin
      rv = side ? b_rvalid : a_rvalid;
      rd = side ? b_rdata  : a_rdata;
      pe = side ? b_perr   : a_perr;
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    {30'd0, a_gnt, b_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check({tag, "_perr"},   {30'd0, a_perr, b_perr}, 32'd0);
    check({tag, "_rdata"},  {16'd0, a_rdata, b_rdata}, 32'd0);
    check({tag, "_errcnt"}, err_cnt, 32'd0);
    check({tag, "_erradr"}, err_addr, 32'd0);
  endtask

  initial begin
    int         gl, ng, nrv, cyc, dbl;
    logic       rv, pe, exp_b;
    logic [7:0] rd;

    rst_n = 1'b0; err_inj = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    tick(); tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // 1: write then immediate read, latency N+1 / N+2
    xact(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, gl, rv, rd, pe);
    check("t1_wr_gnt_lat", gl, 32'd1);
    xact(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, gl, rv, rd, pe);
    check("t1_rd_gnt_lat", gl, 32'd1);
    check("t1_rvalid", rv, 32'd1);
    check("t1_rdata", rd, 32'hA5);
    check("t1_perr", pe, 32'd0);

    // 2: contention after reset -> A first; then A alone moves pointer to B
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h21; a_wdata = 8'h55;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'h3C;
    tick();
    check("t2_first_gnt", {a_gnt, b_gnt}, 32'b10);
    a_req = 1'b0;
    tick();
    check("t2_idle_gnt", {a_gnt, b_gnt}, 32'b00);
    tick();
    check("t2_second_gnt", {a_gnt, b_gnt}, 32'b01);
    b_req = 1'b0;
    tick();
    xact(1'b0, 1'b1, 8'h22, 8'h66, 1'b0, gl, rv, rd, pe);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h21;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    tick();
    check("t2_rep_first_gnt", {a_gnt, b_gnt}, 32'b01);
    b_req = 1'b0;
    tick();
    check("t2_b_rvalid", {a_rvalid, b_rvalid}, 32'b01);
    check("t2_b_rdata", b_rdata, 32'h3C);
    tick(); tick();
    check("t2_rep_second_gnt", {a_gnt, b_gnt}, 32'b10);
    a_req = 1'b0;
    tick();
    check("t2_a_rdata", a_rdata, 32'h55);
    tick();

    // 3: injected parity error on write, detected on read
    xact(1'b0, 1'b1, 8'h05, 8'h0F, 1'b1, gl, rv, rd, pe);
    xact(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, gl, rv, rd, pe);
    check("t3_rdata", rd, 32'h0F);
    check("t3_perr", pe, 32'd1);
    check("t3_err_cnt", err_cnt, 32'd1);
    check("t3_err_addr", err_addr, 32'h05);

    // 4: saturation of err_cnt, reads alternate between sides
    for (int i = 0; i < 256; i++) begin
      xact(i[0], 1'b0, 8'h05, 8'h00, 1'b0, gl, rv, rd, pe);
      if (i == 252) check("t4_err_cnt_254", err_cnt, 32'd254);
    end
    check("t4_last_perr", pe, 32'd1);
    check("t4_err_cnt_sat", err_cnt, 32'd255);
    check("t4_err_addr", err_addr, 32'h05);

    // 5: reset during the ACCESS cycle of a write suppresses it
    xact(1'b0, 1'b1, 8'h30, 8'h11, 1'b0, gl, rv, rd, pe);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 8'h77;
    tick();
    check("t5_gnt_before_rst", a_gnt, 32'd1);
    rst_n = 1'b0;
    a_req = 1'b0;
    tick();
    check_reset_outputs("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    xact(1'b0, 1'b0, 8'h30, 8'h00, 1'b0, gl, rv, rd, pe);
    check("t5_rdata_kept", rd, 32'h11);
    check("t5_perr", pe, 32'd0);

    // 6: sustained contention, pointer currently on B
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    exp_b = 1'b1; ng = 0; nrv = 0; cyc = 0; dbl = 0;
    while ((ng < 20 || nrv < 20) && cyc < 200) begin
      tick();
      cyc++;
      if (a_gnt && b_gnt) dbl++;
      if (a_rvalid && b_rvalid) dbl++;
      if (a_gnt || b_gnt) begin
        check("t6_alternation", b_gnt, {31'd0, exp_b});
        exp_b = ~exp_b;
        ng++;
        if (ng == 20) begin a_req = 1'b0; b_req = 1'b0; end
      end
      if (a_rvalid) begin check("t6_a_rdata", a_rdata, 32'h11); nrv++; end
      if (b_rvalid) begin check("t6_b_rdata", b_rdata, 32'h3C); nrv++; end
    end
    check("t6_grants", ng, 32'd20);
    check("t6_rvalids", nrv, 32'd20);
    check("t6_no_double", dbl, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
